// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified instruction/data memory between the fetch
// stage and the memory stage of the 16-bit core. One transaction is in flight
// at a time. Completion is reported with a registered one-cycle done pulse and
// registered read data. Stall, idle and sticky error flags are generated for
// the hazard logic.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        halt_i,

    input  logic        if_req_i,
    input  logic [15:0] if_addr_i,
    output logic        if_done_o,
    output logic [15:0] if_rdata_o,

    input  logic        d_rd_i,
    input  logic        d_wr_i,
    input  logic [15:0] d_addr_i,
    input  logic [15:0] d_wdata_i,
    output logic        d_done_o,
    output logic [15:0] d_rdata_o,

    output logic        mem_en_o,
    output logic        mem_wr_o,
    output logic [15:0] mem_addr_o,
    output logic [15:0] mem_wdata_o,
    input  logic        mem_done_i,
    input  logic [15:0] mem_rdata_i,

    output logic        stall_if_o,
    output logic        stall_d_o,
    output logic        idle_o,
    output logic        err_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    // Encoding of the last_grant register: which requester won most recently.
    localparam logic GRANT_F = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_grant_q, last_grant_d;
    logic          if_done_q, if_done_d;
    logic          d_done_q, d_done_d;
    logic [15:0]   if_rdata_q, if_rdata_d;
    logic [15:0]   d_rdata_q, d_rdata_d;
    logic          err_q, err_d;

    // Arbitration terms. A requester whose done pulse is high this cycle still
    // holds its old request, so it must not be granted again.
    logic data_req;
    logic data_elig;
    logic fetch_elig;
    logic grant_f;
    logic grant_d;
    logic finish;
    logic [15:0] finish_data;

    assign data_req   = d_rd_i | d_wr_i;
    assign data_elig  = data_req & ~d_done_q & ~rst_i;
    assign fetch_elig = if_req_i & ~halt_i & ~if_done_q & ~rst_i;

    // Pick at most one winner while idle; on a tie the requester that did not
    // win last time goes first.
    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (state_q == IDLE) begin
            if (data_elig && fetch_elig) begin
                if (last_grant_q == GRANT_F) begin
                    grant_d = 1'b1;
                end else begin
                    grant_f = 1'b1;
                end
            end else if (data_elig) begin
                grant_d = 1'b1;
            end else if (fetch_elig) begin
                grant_f = 1'b1;
            end
        end
    end

    // Drive the memory command for the winner in the grant cycle; the command
    // bus rests at zero whenever no command is being issued.
    always_comb begin
        mem_en_o    = grant_f | grant_d;
        mem_wr_o    = 1'b0;
        mem_addr_o  = 16'h0000;
        mem_wdata_o = 16'h0000;
        if (grant_d) begin
            mem_wr_o    = d_wr_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (grant_f) begin
            mem_addr_o  = if_addr_i;
        end
    end

    // Next-state logic: issue from IDLE, then wait for completion or timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        err_d        = err_q;
        finish       = 1'b0;
        finish_data  = mem_rdata_i;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d      = BUSY_D;
                    cnt_d        = '0;
                    last_grant_d = GRANT_D;
                    if (d_rd_i && d_wr_i) begin
                        err_d = 1'b1;
                    end
                end else if (grant_f) begin
                    state_d      = BUSY_F;
                    cnt_d        = '0;
                    last_grant_d = GRANT_F;
                end
            end
            BUSY_F, BUSY_D: begin
                cnt_d = cnt_q + CW'(1);
                if (mem_done_i) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    finish      = 1'b1;
                    finish_data = 16'h0000;
                    err_d       = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Route a completion to the requester that owns the outstanding transaction.
    always_comb begin
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (finish) begin
            if (state_q == BUSY_D) begin
                d_done_d  = 1'b1;
                d_rdata_d = finish_data;
            end else begin
                if_done_d  = 1'b1;
                if_rdata_d = finish_data;
            end
        end
    end

    // State, counter, arbitration history, completion and error registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= GRANT_F;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            if_rdata_q   <= 16'h0000;
            d_rdata_q    <= 16'h0000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    assign if_done_o  = if_done_q;
    assign d_done_o   = d_done_q;
    assign if_rdata_o = if_rdata_q;
    assign d_rdata_o  = d_rdata_q;
    assign err_o      = err_q;

    assign stall_if_o = if_req_i & ~if_done_q;
    assign stall_d_o  = data_req & ~d_done_q;
    assign idle_o     = (state_q == IDLE) & ~(if_req_i | data_req);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer for the 16-bit pipelined core. It shares one unified instruction/data memory between the fetch stage and the memory stage, and issues exactly one transaction at a time. It waits for the memory's completion handshake, then returns read data and a one-cycle done pulse to the winning requester. It also generates the stall signals that the hazard logic uses to freeze the pipeline, and flags illegal requests and memory timeouts.

## Interface
- TIMEOUT, 16: maximum number of cycles to wait for mem_done after issue before aborting.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- halt  in  1  decoded halt; while high, no new fetch is granted (data requests still served).
- if_req  in  1  fetch read request; held high until if_done.
- if_addr  in  16  fetch address.
- if_done  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  16  fetched instruction (registered).
- d_rd  in  1  data read request; held until d_done.
- d_wr  in  1  data write request; held until d_done.
- d_addr  in  16  data address.
- d_wdata  in  16  store data.
- d_done  out  1  one-cycle pulse: data transaction complete; d_rdata valid for reads.
- d_rdata  out  16  load data (registered).
- mem_en  out  1  one-cycle command strobe to memory.
- mem_wr  out  1  write qualifier, valid with mem_en.
- mem_addr  out  16  command address, valid with mem_en.
- mem_wdata  out  16  write data, valid with mem_en.
- mem_done  in  1  memory completion pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  16  memory read data.
- stall_if  out  1  if_req & ~if_done.
- stall_d  out  1  (d_rd | d_wr) & ~d_done.
- idle  out  1  state is IDLE and no request is pending.
- err  out  1  sticky error flag; cleared only by rst.

## Operation
- States: IDLE, BUSY_F (fetch outstanding), BUSY_D (data outstanding).
- IDLE, arbitration, all combinational in the same cycle:
  - Eligible requesters: data if d_rd|d_wr; fetch if if_req & ~halt.
  - A requester whose done output is high this cycle is masked, because its request is still asserted from the completed transaction.
  - Both eligible: the requester other than last_grant wins. last_grant is a 1-bit register set on every grant; its reset value is fetch, so data wins the first tie.
  - One eligible: that requester wins.
  - The winner's address/write/data are driven on mem_*, mem_en=1, and mem_wr=d_wr for data or 0 for fetch. The next state is BUSY_F or BUSY_D, and the wait counter clears to 0.
- BUSY_*:
  - mem_en=0.
  - The counter increments each cycle.
  - On mem_done: capture mem_rdata into the winner's rdata register, pulse the winner's done output in the next cycle, and return to IDLE.
  - If the counter reaches TIMEOUT without mem_done: set err, pulse the winner's done output with rdata=16'h0000, and return to IDLE.
- d_rd & d_wr both high in IDLE: set err, treat the request as a write, and grant it normally.
- mem_done while in IDLE is ignored.
- The rdata registers hold their value until the next completion for the same requester.

## Timing
- Reset values: state IDLE, all done outputs 0, rdata 16'h0000, mem_en 0, mem_wr 0, mem_addr 0, mem_wdata 0, err 0, last_grant fetch, counter 0.
- Request in IDLE at cycle N: mem_en in cycle N.
- If mem_done arrives in cycle N+k (k≥1), done is asserted in cycle N+k+1. Minimum request-to-done latency is 2 cycles.
- The state is IDLE in the done cycle, so a different requester may be issued in that same cycle. Peak throughput is therefore one transaction every 2 cycles.
- Requesters must deassert or change their request in the cycle after done.
- Timeout: done is asserted at cycle N+TIMEOUT+1.
- rst asserted mid-transaction: the outstanding transaction is dropped and no done is produced. The memory must also be reset.

## Test plan
- Single fetch, 1-cycle memory:
  - if_req=1, if_addr=16'h0040 at cycle 0 → mem_en=1, mem_wr=0, mem_addr=16'h0040 at cycle 0.
  - mem_done with mem_rdata=16'hC0DE at cycle 1 → if_done=1, if_rdata=16'hC0DE at cycle 2.
  - stall_if=1 in cycles 0–1.
- Contention:
  - if_req and d_rd asserted together out of reset → data is issued first.
  - Fetch is issued in the cycle d_done pulses, with no idle gap.
  - Second tie → fetch wins.
- Store:
  - d_wr=1, d_addr=16'h0100, d_wdata=16'h1234 → mem_wr=1 with those values for exactly one cycle.
  - d_done follows 1 cycle after mem_done.
- Halt gating:
  - halt=1, if_req=1 → no mem_en; stall_if stays 1; idle=0.
  - d_rd is still served while halt is high.
  - halt=0 → fetch is issued the same cycle.
- Timeout (TIMEOUT=4):
  - mem_done never arrives → done for the winning requester at cycle 5, rdata=0, err=1 and sticky.
  - Subsequent requests are still served.
- Error and reset:
  - d_rd=d_wr=1 → err=1 and a write is issued.
  - rst while in BUSY_D → all outputs take their reset values immediately; no done pulse after rst is released.
